adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 37 +++
 rtl/adder_arbiter_if.sv | 39 +++
 rtl/adder_arbiter_adder.sv | 12 +
 rtl/adder_arbiter.sv | 161 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: widths, FSM encoding
// and the grant-selection rule.
package adder_arbiter_pkg;

  localparam int OPND_W = 4;
  localparam int RES_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Returns the requester id to grant; on a tie round-robin favours the one
  // that did not win last time, fixed priority always favours requester 0.
  function automatic logic pick_grant(
    input logic v0,
    input logic v1,
    input logic last_grant,
    input logic rr_en
  );
    logic g;
    if (v0 && v1) begin
      if (rr_en) begin
        g = ~last_grant;
      end else begin
        g = 1'b0;
      end
    end else if (v1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the two requesters and the adder arbiter.
interface adder_arbiter_if;
  import adder_arbiter_pkg::*;

  logic              req0_valid;
  logic [OPND_W-1:0] req0_a;
  logic [OPND_W-1:0] req0_b;
  logic              req0_ready;
  logic              req1_valid;
  logic [OPND_W-1:0] req1_a;
  logic [OPND_W-1:0] req1_b;
  logic              req1_ready;

  logic              rsp0_valid;
  logic [RES_W-1:0]  rsp0_data;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic [RES_W-1:0]  rsp1_data;
  logic              rsp1_ready;

  logic              busy;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output busy
  );

endinterface

// File: rtl/adder_arbiter_adder.sv
// Existing unsigned adder: two 4-bit operands, zero-extended 8-bit sum.
module adder_arbiter_adder
  import adder_arbiter_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [RES_W-1:0]  r
);

  assign r = {{(RES_W-OPND_W){1'b0}}, a} + {{(RES_W-OPND_W){1'b0}}, b};

endmodule

// File: rtl/adder_arbiter.sv
// Arbitrates two requesters onto one shared adder; a single operation is in
// flight at a time and its result is returned to the requester that won.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);

  localparam logic RR_BIT = (RR_EN != 32'sd0);

  state_e            state_r;
  state_e            state_next_s;
  logic [OPND_W-1:0] opa_r;
  logic [OPND_W-1:0] opb_r;
  logic [OPND_W-1:0] opa_next_s;
  logic [OPND_W-1:0] opb_next_s;
  logic              grant_id_r;
  logic              last_grant_r;
  logic [RES_W-1:0]  result_r;
  logic [RES_W-1:0]  sum_s;

  logic              grant_s;
  logic              hs_s;
  logic              rdy0_s;
  logic              rdy1_s;
  logic              grant_next_s;
  logic [RES_W-1:0]  result_next_s;
  logic              rsp0_valid_next_s;
  logic              rsp1_valid_next_s;
  logic [RES_W-1:0]  rsp0_data_next_s;
  logic [RES_W-1:0]  rsp1_data_next_s;
  logic              busy_next_s;

  logic              rsp0_valid_r;
  logic              rsp1_valid_r;
  logic [RES_W-1:0]  rsp0_data_r;
  logic [RES_W-1:0]  rsp1_data_r;
  logic              busy_r;

  adder_arbiter_adder u_adder (
    .a (opa_r),
    .b (opb_r),
    .r (sum_s)
  );

  // Next-state logic and request acceptance; ready is held low during reset.
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    hs_s         = 1'b0;
    rdy0_s       = 1'b0;
    rdy1_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          grant_s      = pick_grant(bus.req0_valid, bus.req1_valid, last_grant_r, RR_BIT);
          hs_s         = 1'b1;
          rdy0_s       = ~grant_s;
          rdy1_s       = grant_s;
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        state_next_s = ST_RESP;
      end
      ST_RESP: begin
        // Only the granted requester's rsp_ready can release the response.
        if (grant_id_r ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Datapath next values; outputs are decoded from the upcoming state so they register cleanly.
  always_comb begin
    opa_next_s        = opa_r;
    opb_next_s        = opb_r;
    grant_next_s      = grant_id_r;
    result_next_s     = result_r;
    rsp0_valid_next_s = 1'b0;
    rsp1_valid_next_s = 1'b0;
    rsp0_data_next_s  = 8'h00;
    rsp1_data_next_s  = 8'h00;
    busy_next_s       = (state_next_s != ST_IDLE);
    if (hs_s) begin
      opa_next_s   = grant_s ? bus.req1_a : bus.req0_a;
      opb_next_s   = grant_s ? bus.req1_b : bus.req0_b;
      grant_next_s = grant_s;
    end else begin
      grant_next_s = grant_id_r;
    end
    if (state_r == ST_CALC) begin
      result_next_s = sum_s;
    end else begin
      result_next_s = result_r;
    end
    if (state_next_s == ST_RESP) begin
      rsp0_valid_next_s = ~grant_next_s;
      rsp1_valid_next_s = grant_next_s;
      rsp0_data_next_s  = grant_next_s ? 8'h00 : result_next_s;
      rsp1_data_next_s  = grant_next_s ? result_next_s : 8'h00;
    end else begin
      rsp0_valid_next_s = 1'b0;
      rsp1_valid_next_s = 1'b0;
    end
  end

  // State, operand/grant capture, result register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      opa_r        <= 4'd0;
      opb_r        <= 4'd0;
      grant_id_r   <= 1'b0;
      last_grant_r <= 1'b1;
      result_r     <= 8'h00;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_data_r  <= 8'h00;
      rsp1_data_r  <= 8'h00;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      opa_r        <= opa_next_s;
      opb_r        <= opb_next_s;
      grant_id_r   <= grant_next_s;
      if (hs_s) begin
        last_grant_r <= grant_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
      result_r     <= result_next_s;
      rsp0_valid_r <= rsp0_valid_next_s;
      rsp1_valid_r <= rsp1_valid_next_s;
      rsp0_data_r  <= rsp0_data_next_s;
      rsp1_data_r  <= rsp1_data_next_s;
      busy_r       <= busy_next_s;
    end
  end

  assign bus.req0_ready = rdy0_s;
  assign bus.req1_ready = rdy1_s;
  assign bus.rsp0_valid = rsp0_valid_r;
  assign bus.rsp1_valid = rsp1_valid_r;
  assign bus.rsp0_data  = rsp0_data_r;
  assign bus.rsp1_data  = rsp1_data_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a round-robin and a fixed-priority instance share
// the same directed stimulus and are checked every cycle against a transaction model.
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;

  always #5 clk = ~clk;

  adder_arbiter_if i0 ();
  adder_arbiter_if i1 ();

  assign i0.req0_valid = req0_valid;
  assign i0.req0_a     = req0_a;
  assign i0.req0_b     = req0_b;
  assign i0.req1_valid = req1_valid;
  assign i0.req1_a     = req1_a;
  assign i0.req1_b     = req1_b;
  assign i0.rsp0_ready = rsp0_ready;
  assign i0.rsp1_ready = rsp1_ready;
  assign i1.req0_valid = req0_valid;
  assign i1.req0_a     = req0_a;
  assign i1.req0_b     = req0_b;
  assign i1.req1_valid = req1_valid;
  assign i1.req1_a     = req1_a;
  assign i1.req1_b     = req1_b;
  assign i1.rsp0_ready = rsp0_ready;
  assign i1.rsp1_ready = rsp1_ready;

  adder_arbiter #(.RR_EN(1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  adder_arbiter #(.RR_EN(0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  typedef struct packed {
    logic       rdy0;
    logic       rdy1;
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       busy;
  } obs_t;

  obs_t obs [2];
  assign obs[0] = {i0.req0_ready, i0.req1_ready, i0.rsp0_valid, i0.rsp1_valid,
                   i0.rsp0_data, i0.rsp1_data, i0.busy};
  assign obs[1] = {i1.req0_ready, i1.req1_ready, i1.rsp0_valid, i1.rsp1_valid,
                   i1.rsp0_data, i1.rsp1_data, i1.busy};

  int errors = 0;
  int checks = 0;
  int fp_req1_rdy = 0;
  bit tie_window = 1'b0;
  logic [8:0] rlog0 [$];
  logic [8:0] rlog1 [$];

  // Transaction model: is an operation in flight, how many edges old, whose, what sum.
  bit         m_busy  [2];
  int         m_age   [2];
  bit         m_owner [2];
  logic [7:0] m_sum   [2];
  bit         m_last  [2];

  task automatic check(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h required=%h", name, d, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge.
  initial begin
    bit         g, any, rr, e_r0, e_r1, e_v0, e_v1, e_busy;
    logic [7:0] e_d0, e_d1;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_age[d]  = 0;
      m_owner[d] = 1'b0;
      m_sum[d]  = 8'h00;
      m_last[d] = 1'b1;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rr  = (d == 0);
        any = req0_valid || req1_valid;
        if (req0_valid && req1_valid) g = rr ? !m_last[d] : 1'b0;
        else g = req1_valid;
        e_r0   = rst_n && !m_busy[d] && any && !g;
        e_r1   = rst_n && !m_busy[d] && any && g;
        e_busy = m_busy[d];
        e_v0   = m_busy[d] && (m_age[d] >= 2) && !m_owner[d];
        e_v1   = m_busy[d] && (m_age[d] >= 2) && m_owner[d];
        e_d0   = e_v0 ? m_sum[d] : 8'h00;
        e_d1   = e_v1 ? m_sum[d] : 8'h00;
        check("req0_ready", d, {7'd0, obs[d].rdy0}, {7'd0, e_r0});
        check("req1_ready", d, {7'd0, obs[d].rdy1}, {7'd0, e_r1});
        check("rsp0_valid", d, {7'd0, obs[d].v0}, {7'd0, e_v0});
        check("rsp1_valid", d, {7'd0, obs[d].v1}, {7'd0, e_v1});
        check("rsp0_data", d, obs[d].d0, e_d0);
        check("rsp1_data", d, obs[d].d1, e_d1);
        check("busy", d, {7'd0, obs[d].busy}, {7'd0, e_busy});
        if (obs[d].v0 === 1'b1 && rsp0_ready && rst_n) begin
          if (d == 0) rlog0.push_back({1'b0, obs[d].d0});
          else rlog1.push_back({1'b0, obs[d].d0});
        end
        if (obs[d].v1 === 1'b1 && rsp1_ready && rst_n) begin
          if (d == 0) rlog0.push_back({1'b1, obs[d].d1});
          else rlog1.push_back({1'b1, obs[d].d1});
        end
        if (d == 1 && tie_window && obs[1].rdy1 === 1'b1) fp_req1_rdy++;
        if (!rst_n) begin
          m_busy[d] = 1'b0;
          m_last[d] = 1'b1;
        end else if (!m_busy[d]) begin
          if (any) begin
            m_busy[d]  = 1'b1;
            m_age[d]   = 1;
            m_owner[d] = g;
            m_sum[d]   = g ? ({4'd0, req1_a} + {4'd0, req1_b}) : ({4'd0, req0_a} + {4'd0, req0_b});
            m_last[d]  = g;
          end
        end else if (m_age[d] == 1) begin
          m_age[d] = 2;
        end else if (m_owner[d] ? rsp1_ready : rsp0_ready) begin
          m_busy[d] = 1'b0;
        end
      end
    end
  end

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    logic [8:0] exp_rr [4];
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
    tick();
    tick();
    @(negedge clk);
    check("lit_rst_busy", 0, {7'd0, i0.busy}, 8'd0);
    check("lit_rst_rsp0_valid", 0, {7'd0, i0.rsp0_valid}, 8'd0);
    check("lit_rst_rsp1_data", 0, i0.rsp1_data, 8'h00);
    tick();
    rst_n = 1'b1;

    // Lone requester 0, 9+7.
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd7; rsp0_ready = 1'b1;
    @(negedge clk);
    check("lit_a_req0_ready", 0, {7'd0, i0.req0_ready}, 8'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("lit_a_calc_busy", 0, {7'd0, i0.busy}, 8'd1);
    check("lit_a_calc_rsp0", 0, {7'd0, i0.rsp0_valid}, 8'd0);
    tick();
    @(negedge clk);
    check("lit_a_rsp0_valid", 0, {7'd0, i0.rsp0_valid}, 8'd1);
    check("lit_a_rsp0_data", 0, i0.rsp0_data, 8'h10);
    check("lit_a_rsp1_valid", 0, {7'd0, i0.rsp1_valid}, 8'd0);
    tick();
    @(negedge clk);
    check("lit_a_idle_busy", 0, {7'd0, i0.busy}, 8'd0);

    // Requester 1, 5+6, response held off; rsp0_ready toggles meanwhile.
    tick();
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd6; rsp1_ready = 1'b0; rsp0_ready = 1'b0;
    tick();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lit_b_rsp1_valid", 1, {7'd0, i1.rsp1_valid}, 8'd1);
      check("lit_b_rsp1_data", 1, i1.rsp1_data, 8'h0B);
      check("lit_b_req0_ready", 1, {7'd0, i1.req0_ready}, 8'd0);
      tick();
      rsp0_ready = ~rsp0_ready;
    end
    rsp1_ready = 1'b1; req0_valid = 1'b0;
    tick();
    @(negedge clk);
    check("lit_b_idle_busy", 1, {7'd0, i1.busy}, 8'd0);

    // Reset during CALC aborts the operation.
    tick();
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    tick();
    req0_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("lit_c_busy", 0, {7'd0, i0.busy}, 8'd0);
    tick();
    @(negedge clk);
    check("lit_c_no_rsp0", 0, {7'd0, i0.rsp0_valid}, 8'd0);
    tick();
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; rsp1_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    check("lit_c_rsp1_data", 0, i0.rsp1_data, 8'h02);
    tick();

    // Both requesters valid continuously after reset.
    rst_n = 1'b0;
    tick();
    tick();
    rlog0.delete();
    rlog1.delete();
    rst_n = 1'b1; tie_window = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd4;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (12) tick();
    tie_window = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    exp_rr[0] = 9'h007; exp_rr[1] = 9'h11E; exp_rr[2] = 9'h007; exp_rr[3] = 9'h11E;
    check("lit_d_rr_count", 0, rlog0.size() > 255 ? 8'hFF : 8'(rlog0.size()), 8'd4);
    check("lit_d_fp_count", 1, rlog1.size() > 255 ? 8'hFF : 8'(rlog1.size()), 8'd4);
    for (int i = 0; i < 4; i++) begin
      check("lit_d_rr_owner", 0, {7'd0, (i < rlog0.size()) ? rlog0[i][8] : 1'bx}, {7'd0, exp_rr[i][8]});
      check("lit_d_rr_data", 0, (i < rlog0.size()) ? rlog0[i][7:0] : 8'hxx, exp_rr[i][7:0]);
      check("lit_d_fp_entry", 1, (i < rlog1.size()) ? rlog1[i][7:0] : 8'hxx, 8'h07);
    end
    check("lit_d_fp_req1_ready", 1, fp_req1_rdy > 255 ? 8'hFF : 8'(fp_req1_rdy), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
